// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD reset sequencer: FSM encoding,
// Avalon register addresses and register bit positions.
package lcd_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RECOVER = 2'd2,
      ST_READY   = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_ASSERT  = 2'd2;
   localparam logic [1:0] ADDR_RECOVER = 2'd3;

   // CONTROL register bits
   localparam int CTRL_START  = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS register bits
   localparam int STAT_BUSY  = 0;
   localparam int STAT_READY = 1;
   localparam int STAT_DONE  = 2;

endpackage

// File: rtl/lcd_seq_timer.sv
// Loadable down-counter used to time the reset and recovery phases.
// Load wins over enable; the count parks at zero rather than wrapping.
module lcd_seq_timer #(
   parameter int CNT_W = 24
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   // Count register: load a new interval or step down towards zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/lcd_reset_sequencer.sv
// Avalon-MM slave that drives the LCD panel reset pin with a timed
// power-up pulse, then waits a recovery interval before flagging ready.
module lcd_reset_sequencer #(
   parameter int CNT_W       = 24,
   parameter int DEF_ASSERT  = 50000,
   parameter int DEF_RECOVER = 6000000,
   parameter int AUTO_START  = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic        read_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic        lcd_rst_n_out,
   output logic        lcd_ready
);

   import lcd_seq_pkg::*;

   // A programmed count of N means N cycles; 0 is treated as 1.
   function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] cycles);
      return (cycles == '0) ? '0 : cycles - CNT_W'(1);
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_assert_cyc;
   logic [CNT_W-1:0] r_recover_cyc;
   logic             r_irq_en;
   logic             r_start_pending;
   logic             r_done;
   logic             r_lcd_rst_n;
   logic             r_lcd_ready;
   logic [31:0]      r_readdata;

   logic             w_wr;
   logic             w_rd;
   logic             w_start;
   logic             w_abort;
   logic             w_done_clr;
   logic             w_busy;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_set_done;
   logic             w_clr_pending;
   logic             w_tmr_zero;
   logic [31:0]      w_rdata;
   logic             w_unused_wdata;

   assign w_wr       = chipselect && !write_n;
   assign w_rd       = chipselect && !read_n;
   assign w_start    = w_wr && (address == ADDR_CTRL) && writedata[CTRL_START];
   assign w_abort    = w_wr && (address == ADDR_CTRL) && writedata[CTRL_ABORT];
   assign w_done_clr = w_wr && (address == ADDR_STATUS) && writedata[STAT_DONE];
   assign w_busy     = (r_state == ST_ASSERT) || (r_state == ST_RECOVER);

   // Upper write-data bits are ignored by every register.
   assign w_unused_wdata = ^writedata;

   lcd_seq_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .i_clk      (clk),
      .i_rst_n    (reset_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_en       (w_busy),
      .o_zero     (w_tmr_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and timer loads; ABORT overrides everything.
   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_load_val    = '0;
      w_set_done    = 1'b0;
      w_clr_pending = 1'b0;
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start || r_start_pending) begin
                  w_load        = 1'b1;
                  w_load_val    = load_value(r_assert_cyc);
                  w_clr_pending = 1'b1;
                  w_state_nxt   = ST_ASSERT;
               end
            end
            ST_ASSERT: begin
               if (w_tmr_zero) begin
                  w_load      = 1'b1;
                  w_load_val  = load_value(r_recover_cyc);
                  w_state_nxt = ST_RECOVER;
               end
            end
            ST_RECOVER: begin
               if (w_tmr_zero) begin
                  w_set_done  = 1'b1;
                  w_state_nxt = ST_READY;
               end
            end
            ST_READY: begin
               if (w_start) begin
                  w_load      = 1'b1;
                  w_load_val  = load_value(r_assert_cyc);
                  w_state_nxt = ST_ASSERT;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Software-visible registers, done flag and the auto-start request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_assert_cyc    <= CNT_W'(DEF_ASSERT);
         r_recover_cyc   <= CNT_W'(DEF_RECOVER);
         r_irq_en        <= 1'b0;
         r_start_pending <= (AUTO_START != 0);
         r_done          <= 1'b0;
      end else begin
         if (w_wr && (address == ADDR_CTRL)) begin
            r_irq_en <= writedata[CTRL_IRQ_EN];
         end
         if (w_wr && (address == ADDR_ASSERT)) begin
            r_assert_cyc <= writedata[CNT_W-1:0];
         end
         if (w_wr && (address == ADDR_RECOVER)) begin
            r_recover_cyc <= writedata[CNT_W-1:0];
         end
         if (w_clr_pending) begin
            r_start_pending <= 1'b0;
         end
         // A completion in the same cycle as a clear-write keeps done set.
         if (w_set_done) begin
            r_done <= 1'b1;
         end else if (w_done_clr) begin
            r_done <= 1'b0;
         end
      end
   end

   // Pin outputs follow the next state so they are registered and glitch-free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lcd_rst_n <= 1'b0;
         r_lcd_ready <= 1'b0;
      end else begin
         r_lcd_rst_n <= (w_state_nxt == ST_RECOVER) || (w_state_nxt == ST_READY);
         r_lcd_ready <= (w_state_nxt == ST_READY);
      end
   end

   // Read-data mux; unused bits read zero.
   always_comb begin
      w_rdata = '0;
      case (address)
         ADDR_CTRL: begin
            w_rdata[CTRL_IRQ_EN] = r_irq_en;
         end
         ADDR_STATUS: begin
            w_rdata[STAT_BUSY]  = w_busy;
            w_rdata[STAT_READY] = r_lcd_ready;
            w_rdata[STAT_DONE]  = r_done;
         end
         ADDR_ASSERT:  w_rdata = 32'(r_assert_cyc);
         ADDR_RECOVER: w_rdata = 32'(r_recover_cyc);
         default:      w_rdata = '0;
      endcase
   end

   // Registered read data, held between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
      end else if (w_rd) begin
         r_readdata <= w_rdata;
      end
   end

   assign readdata      = r_readdata;
   assign irq           = r_done && r_irq_en;
   assign lcd_rst_n_out = r_lcd_rst_n;
   assign lcd_ready     = r_lcd_ready;

endmodule

// File: tb/tb_lcd_reset_sequencer.sv
// Bench for lcd_reset_sequencer: a scoreboard of expected pin edges
// (value and cycle) and expected read data, drained by monitors.
`timescale 1ns/1ps
module tb_lcd_reset_sequencer;

   localparam int CNT_W = 24;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        cs1, cs2, write_n, read_n;
   logic [31:0] writedata;
   logic [31:0] rd1, rd2;
   logic        irq1, irq2, rst1, rst2, rdy1, rdy2;

   always #5 clk = ~clk;

   lcd_reset_sequencer #(
      .CNT_W(CNT_W), .DEF_ASSERT(4), .DEF_RECOVER(6), .AUTO_START(1)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
      .write_n(write_n), .read_n(read_n), .writedata(writedata),
      .readdata(rd1), .irq(irq1), .lcd_rst_n_out(rst1), .lcd_ready(rdy1)
   );

   lcd_reset_sequencer #(
      .CNT_W(CNT_W), .DEF_ASSERT(4), .DEF_RECOVER(6), .AUTO_START(0)
   ) u_dut_man (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
      .write_n(write_n), .read_n(read_n), .writedata(writedata),
      .readdata(rd2), .irq(irq2), .lcd_rst_n_out(rst2), .lcd_ready(rdy2)
   );

   typedef struct { int cyc; logic val; } edge_t;
   typedef struct { int id; logic [1:0] addr; logic [31:0] val; } rd_t;

   edge_t q_rst[$];
   edge_t q_rdy[$];
   rd_t   q_rd[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   int    rd_id    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_edge(input logic is_rdy, input logic v, input int c);
      edge_t e;
      e.cyc = c;
      e.val = v;
      if (is_rdy) q_rdy.push_back(e);
      else        q_rst.push_back(e);
   endtask

   task automatic bus_write(input logic sel2, input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write_n   = 1'b0;
      cs1       = !sel2;
      cs2       = sel2;
      @(negedge clk);
      write_n = 1'b1;
      cs1     = 1'b0;
      cs2     = 1'b0;
   endtask

   task automatic bus_read1(input logic [1:0] a, input logic [31:0] exp);
      rd_t r;
      r.id   = rd_id;
      r.addr = a;
      r.val  = exp;
      rd_id  = rd_id + 1;
      q_rd.push_back(r);
      address = a;
      read_n  = 1'b0;
      cs1     = 1'b1;
      @(negedge clk);
      read_n = 1'b1;
      cs1    = 1'b0;
   endtask

   task automatic bus_read2(input logic [1:0] a);
      address = a;
      read_n  = 1'b0;
      cs2     = 1'b1;
      @(negedge clk);
      read_n = 1'b1;
      cs2    = 1'b0;
   endtask

   // Pin-edge monitor: every change must match the next expected edge.
   initial begin : edge_mon
      logic  p_rst, p_rdy;
      edge_t e;
      @(negedge clk);
      p_rst = rst1;
      p_rdy = rdy1;
      forever begin
         @(negedge clk);
         if (rst1 !== p_rst) begin
            n_checks++;
            if (q_rst.size() == 0) begin
               n_fail++;
               $display("FAIL lcd_rst_n_out: unexpected edge to %0b at cycle %0d", rst1, cyc);
            end else begin
               e = q_rst.pop_front();
               if (rst1 !== e.val || cyc != e.cyc) begin
                  n_fail++;
                  $display("FAIL lcd_rst_n_out edge: got %0b at cycle %0d, expected %0b at cycle %0d",
                           rst1, cyc, e.val, e.cyc);
               end
            end
            p_rst = rst1;
         end
         if (rdy1 !== p_rdy) begin
            n_checks++;
            if (q_rdy.size() == 0) begin
               n_fail++;
               $display("FAIL lcd_ready: unexpected edge to %0b at cycle %0d", rdy1, cyc);
            end else begin
               e = q_rdy.pop_front();
               if (rdy1 !== e.val || cyc != e.cyc) begin
                  n_fail++;
                  $display("FAIL lcd_ready edge: got %0b at cycle %0d, expected %0b at cycle %0d",
                           rdy1, cyc, e.val, e.cyc);
               end
            end
            p_rdy = rdy1;
         end
      end
   end

   // Read monitor: readdata is compared one cycle after each read strobe.
   initial begin : rd_mon
      logic s;
      rd_t  r;
      forever begin
         @(posedge clk);
         s = cs1 && !read_n;
         @(negedge clk);
         if (s) begin
            n_checks++;
            if (q_rd.size() == 0) begin
               n_fail++;
               $display("FAIL readdata: unexpected read, got 0x%0h", rd1);
            end else begin
               r = q_rd.pop_front();
               if (rd1 !== r.val) begin
                  n_fail++;
                  $display("FAIL readdata #%0d addr %0d: got 0x%0h, expected 0x%0h",
                           r.id, r.addr, rd1, r.val);
               end
            end
         end
      end
   end

   initial begin : stim
      int c, n, m, k;
      reset_n   = 1'b0;
      cs1       = 1'b0;
      cs2       = 1'b0;
      read_n    = 1'b1;
      write_n   = 1'b1;
      address   = 2'd0;
      writedata = 32'd0;
      repeat (3) @(negedge clk);

      // Reset state of both instances
      check("rst1 in reset",   32'(rst1), 32'd0);
      check("rdy1 in reset",   32'(rdy1), 32'd0);
      check("irq1 in reset",   32'(irq1), 32'd0);
      check("rd1 in reset",    rd1,       32'd0);
      check("rst2 in reset",   32'(rst2), 32'd0);
      check("rdy2 in reset",   32'(rdy2), 32'd0);
      check("irq2 in reset",   32'(irq2), 32'd0);
      check("rd2 in reset",    rd2,       32'd0);

      // Power-up: one IDLE cycle, 4 assert cycles, 6 recovery cycles
      c = cyc;
      exp_edge(1'b0, 1'b1, c + 5);
      exp_edge(1'b1, 1'b1, c + 11);
      reset_n = 1'b1;
      repeat (14) @(negedge clk);
      check("man rst stays low", 32'(rst2), 32'd0);
      check("man rdy stays low", 32'(rdy2), 32'd0);
      bus_read1(2'd1, 32'h6);
      bus_read1(2'd0, 32'h0);
      bus_read1(2'd2, 32'd4);
      bus_read1(2'd3, 32'd6);
      check("irq1 after power-up", 32'(irq1), 32'd0);

      // Manual instance: zero counts act as 1, START with IRQ_EN
      bus_write(1'b1, 2'd2, 32'd0);
      bus_write(1'b1, 2'd3, 32'd0);
      bus_write(1'b1, 2'd0, 32'h5);
      check("man rst in assert", 32'(rst2), 32'd0);
      @(negedge clk);
      check("man rst released", 32'(rst2), 32'd1);
      check("man rdy in recover", 32'(rdy2), 32'd0);
      @(negedge clk);
      check("man rdy up", 32'(rdy2), 32'd1);
      check("man irq up", 32'(irq2), 32'd1);
      bus_write(1'b1, 2'd1, 32'h4);
      check("man irq cleared", 32'(irq2), 32'd0);
      bus_read2(2'd1);
      check("man status", rd2, 32'h2);
      bus_read2(2'd2);
      check("man assert reg", rd2, 32'h0);

      // Re-reset from READY; a second START mid-ASSERT is ignored
      n = cyc + 1;
      exp_edge(1'b0, 1'b0, n);
      exp_edge(1'b1, 1'b0, n);
      exp_edge(1'b0, 1'b1, n + 4);
      exp_edge(1'b1, 1'b1, n + 10);
      bus_write(1'b0, 2'd0, 32'h1);
      bus_read1(2'd1, 32'h5);
      bus_write(1'b0, 2'd0, 32'h1);
      repeat (12) @(negedge clk);
      bus_read1(2'd1, 32'h6);

      // IRQ enable and done clear
      bus_write(1'b0, 2'd0, 32'h4);
      check("irq1 enabled", 32'(irq1), 32'd1);
      bus_read1(2'd0, 32'h4);
      bus_write(1'b0, 2'd1, 32'h4);
      check("irq1 cleared", 32'(irq1), 32'd0);
      bus_read1(2'd1, 32'h2);

      // ABORT during RECOVER after a count write; next START uses 10
      n = cyc + 1;
      exp_edge(1'b0, 1'b0, n);
      exp_edge(1'b1, 1'b0, n);
      exp_edge(1'b0, 1'b1, n + 4);
      bus_write(1'b0, 2'd0, 32'h5);
      repeat (4) @(negedge clk);
      bus_write(1'b0, 2'd2, 32'd10);
      m = cyc + 1;
      exp_edge(1'b0, 1'b0, m);
      bus_write(1'b0, 2'd0, 32'h6);
      check("irq1 after abort", 32'(irq1), 32'd0);
      bus_read1(2'd1, 32'h0);
      repeat (8) @(negedge clk);
      check("irq1 stays low", 32'(irq1), 32'd0);
      k = cyc + 1;
      exp_edge(1'b0, 1'b1, k + 10);
      exp_edge(1'b1, 1'b1, k + 16);
      bus_write(1'b0, 2'd0, 32'h5);
      repeat (18) @(negedge clk);
      check("irq1 after 10-cycle run", 32'(irq1), 32'd1);
      bus_read1(2'd1, 32'h6);

      // Asynchronous reset mid-ASSERT
      bus_write(1'b0, 2'd2, 32'd7);
      n = cyc + 1;
      exp_edge(1'b0, 1'b0, n);
      exp_edge(1'b1, 1'b0, n);
      bus_write(1'b0, 2'd0, 32'h5);
      check("irq1 before async reset", 32'(irq1), 32'd1);
      bus_read1(2'd2, 32'd7);
      #2 reset_n = 1'b0;
      #1;
      check("rd1 async reset",  rd1,       32'd0);
      check("irq1 async reset", 32'(irq1), 32'd0);
      check("rst1 async reset", 32'(rst1), 32'd0);
      check("rdy1 async reset", 32'(rdy1), 32'd0);
      repeat (3) @(negedge clk);
      c = cyc;
      exp_edge(1'b0, 1'b1, c + 5);
      exp_edge(1'b1, 1'b1, c + 11);
      reset_n = 1'b1;
      bus_read1(2'd2, 32'd4);
      bus_read1(2'd3, 32'd6);
      bus_read1(2'd0, 32'h0);
      repeat (12) @(negedge clk);
      bus_read1(2'd1, 32'h6);
      check("irq1 after re-power", 32'(irq1), 32'd0);

      // ABORT beats START in the same write; done is kept
      n = cyc + 1;
      exp_edge(1'b0, 1'b0, n);
      exp_edge(1'b1, 1'b0, n);
      bus_write(1'b0, 2'd0, 32'h3);
      repeat (8) @(negedge clk);
      bus_read1(2'd1, 32'h4);

      // Every expected edge and read must have been consumed
      repeat (2) @(negedge clk);
      check("pending rst edges", 32'(q_rst.size()), 32'd0);
      check("pending rdy edges", 32'(q_rdy.size()), 32'd0);
      check("pending reads",     32'(q_rd.size()),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_reset_sequencer.md
Name: lcd_reset_sequencer

Overview:
Avalon-MM slave that owns the LCD panel reset pin and generates a timed power-up reset pulse, so software no longer bit-bangs the reset PIO with delay loops. It holds the pin low for a programmable assert time, then releases it and waits a programmable recovery time before it flags the panel ready. It sits in the SOPC system beside the LCD data interface. Its ready flag and completion interrupt gate the LCD driver's first command.

Parameters:
CNT_W, 24, width of the timing counters and count registers
DEF_ASSERT, 50000, reset value of ASSERT_CYCLES (1 ms at 50 MHz)
DEF_RECOVER, 6000000, reset value of RECOVER_CYCLES (120 ms at 50 MHz)
AUTO_START, 1, when 1 the sequence starts by itself after reset deasserts

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset_n  input  1  asynchronous active-low reset
address  input  2  register select
chipselect  input  1  Avalon slave select
write_n  input  1  active-low write strobe
read_n  input  1  active-low read strobe
writedata  input  32  write data
readdata  output  32  read data, registered
irq  output  1  completion interrupt, level-sensitive
lcd_rst_n_out  output  1  drives the LCD reset pin (low = panel in reset)
lcd_ready  output  1  high when the panel is out of reset and recovered

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - lcd_rst_n_out=0, lcd_ready=0, irq=0, readdata=0.
  - State IDLE; counter=0.
  - ASSERT_CYCLES=DEF_ASSERT, RECOVER_CYCLES=DEF_RECOVER, irq_en=0.
  - start_pending=AUTO_START.
- Register map (a write occurs when chipselect && !write_n; a read when chipselect && !read_n):
  - 0 CONTROL (write): bit0 START, bit1 ABORT, bit2 IRQ_EN. IRQ_EN is stored; START and ABORT are single-cycle strobes. Reading address 0 returns {29'b0, IRQ_EN, 2'b0}.
  - 1 STATUS (read): bit0 busy, bit1 ready, bit2 done. Writing 1 to bit2 clears done. Other bits read 0.
  - 2 ASSERT_CYCLES (read/write): lower CNT_W bits used.
  - 3 RECOVER_CYCLES (read/write): lower CNT_W bits used.
  - Read data is registered: readdata is valid on the cycle after the read strobe. readdata holds its value when no read is in progress.
- FSM states: IDLE, ASSERT, RECOVER, READY.
  - IDLE: lcd_rst_n_out=0. On START or start_pending: load counter with max(ASSERT_CYCLES,1)-1, clear start_pending, go to ASSERT.
  - ASSERT: lcd_rst_n_out=0, busy=1. Counter decrements each cycle. When counter==0: load counter with max(RECOVER_CYCLES,1)-1, go to RECOVER.
  - RECOVER: lcd_rst_n_out=1, busy=1. When counter==0: go to READY and set done.
  - READY: lcd_rst_n_out=1, lcd_ready=1. On START: re-enter ASSERT with a fresh load. This is the software re-reset path.
- Latency: lcd_rst_n_out is low for exactly max(ASSERT_CYCLES,1) cycles. After release, lcd_ready rises exactly max(RECOVER_CYCLES,1) cycles later.
- Count-register writes during busy affect only the next load. A count value of 0 is treated as 1.
- START during ASSERT or RECOVER is ignored.
- ABORT in any state: go to IDLE next cycle with lcd_rst_n_out=0 and lcd_ready=0. done is unchanged and no irq is raised. ABORT has priority over a START in the same cycle.
- done set and a clear-write in the same cycle: set wins.
- irq = done && IRQ_EN.
- lcd_rst_n_out and lcd_ready are registered and glitch-free. Asynchronous reset mid-sequence returns all outputs to reset values immediately.

Decomposition:
- Package lcd_seq_pkg holds:
  - the state encoding;
  - register address constants (ADDR_CTRL=0, ADDR_STATUS=1, ADDR_ASSERT=2, ADDR_RECOVER=3);
  - bit-position constants for CONTROL and STATUS.
- One natural sub-module, lcd_seq_timer: a loadable CNT_W down-counter with load, enable and zero-flag.
- The register file and FSM stay in the top module.

Test Plan:
- Power-up, AUTO_START=1, DEF_ASSERT=4, DEF_RECOVER=6 -> lcd_rst_n_out low for 4 cycles after reset release, then high; lcd_ready rises 6 cycles later; STATUS reads 0x6.
- AUTO_START=0, write ASSERT=0, RECOVER=0, then CONTROL=0x5 -> 1-cycle low pulse, lcd_ready 1 cycle after release, irq=1; write STATUS=0x4 -> irq=0 and done=0.
- From READY, write CONTROL=0x1 -> lcd_ready drops next cycle and a fresh 4-cycle low pulse occurs; a second START issued mid-ASSERT does not lengthen the pulse.
- During RECOVER, write ASSERT=10 and then ABORT -> state IDLE, lcd_rst_n_out=0, done unchanged, irq stays 0; a following START gives a 10-cycle pulse.
- Assert reset_n mid-ASSERT -> outputs return to reset values asynchronously and the count registers revert to their defaults.
- Read each register back -> readdata is valid exactly one cycle after the strobe; unused bits read 0.
